// File: rtl/data_mem_pkg.sv
// data_mem_pkg: FSM states and address-field width helpers for the set-associative data cache
package data_mem_pkg;
   typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
   function automatic int off_w(int words_per_line);
      return $clog2(words_per_line);
   endfunction
   function automatic int idx_w(int sets);
      return $clog2(sets);
   endfunction
   function automatic int tag_w(int addr_w, int words_per_line, int sets);
      return addr_w - off_w(words_per_line) - idx_w(sets);
   endfunction
endpackage

// File: rtl/main_mem_line.sv
// main_mem_line: line-wide backing store with fixed latency; lines are kept XORed with their own word addresses so the zero power-up image reads as mem[a]=a
module main_mem_line #(
   parameter int LINE_AW = 8,
   parameter int DATA_W = 32,
   parameter int OFF_W = 2,
   parameter int LINE_W = 128,
   parameter int MEM_LAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [LINE_AW-1:0] line_addr,
   input  logic [LINE_W-1:0] wdata,
   output logic [LINE_W-1:0] rdata,
   output logic              ack
);
   localparam int CW = $clog2(MEM_LAT + 1);
   localparam int WPL = LINE_W / DATA_W;
   logic [CW-1:0] cnt;
   logic [LINE_W-1:0] mem [2**LINE_AW] = '{default: '0};
   function automatic logic [LINE_W-1:0] ident(logic [LINE_AW-1:0] la);
      logic [LINE_W-1:0] v;
      for (int w = 0; w < WPL; w++) v[w*DATA_W +: DATA_W] = DATA_W'({la, OFF_W'(w)});
      return v;
   endfunction
   assign ack = req && cnt == CW'(MEM_LAT - 1);
   assign rdata = mem[line_addr] ^ ident(line_addr);
   always_ff @(posedge clk)
      if (reset) cnt <= '0;
      else begin
         cnt <= ack ? '0 : req ? cnt + CW'(1) : cnt;
         if (ack && we) mem[line_addr] <= wdata ^ ident(line_addr);
      end
endmodule

// File: rtl/data_mem_sys_assoc.sv
// data_mem_sys_assoc: N-way set-associative write-back/write-allocate data cache with round-robin replacement over a multi-cycle line memory
module data_mem_sys_assoc import data_mem_pkg::*; #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int WAYS = 2,
   parameter int SETS = 8,
   parameter int WORDS_PER_LINE = 4,
   parameter int MEM_LAT = 4,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              stall,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);
   localparam int OFF_W = off_w(WORDS_PER_LINE);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(ADDR_W, WORDS_PER_LINE, SETS);
   localparam int LINE_W = DATA_W * WORDS_PER_LINE;
   localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
   state_t state;
   logic [WAYS-1:0] valid [SETS];
   logic [WAYS-1:0] dirty [SETS];
   logic [TAG_W-1:0] tags [SETS][WAYS];
   logic [LINE_W-1:0] lines [SETS][WAYS];
   logic [WAY_W-1:0] rr [SETS];
   logic [WAY_W-1:0] vic, hit_way, free_way, victim;
   logic [TAG_W-1:0] tag;
   logic [IDX_W-1:0] idx;
   logic [OFF_W-1:0] off;
   logic hit, has_free, req, ack;
   logic [LINE_W-1:0] rdata;
   assign {tag, idx, off} = addr;
   assign req = MemRead | MemWrite;
   always_comb begin
      hit = 1'b0;
      hit_way = '0;
      has_free = 1'b0;
      free_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[idx][w] && tags[idx][w] == tag) begin
            hit = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid[idx][w]) begin
            has_free = 1'b1;
            free_way = WAY_W'(w);
         end
      end
   end
   assign victim = has_free ? free_way : rr[idx];
   assign stall = state != IDLE || (req && !hit);
   main_mem_line #(
      .LINE_AW(TAG_W + IDX_W), .DATA_W(DATA_W), .OFF_W(OFF_W), .LINE_W(LINE_W), .MEM_LAT(MEM_LAT)
   ) u_mem (
      .clk(clk),
      .reset(reset),
      .req(state != IDLE),
      .we(state == WRITEBACK),
      .line_addr(state == WRITEBACK ? {tags[idx][vic], idx} : {tag, idx}),
      .wdata(lines[idx][vic]),
      .rdata(rdata),
      .ack(ack)
   );
   always_ff @(posedge clk)
      if (reset) begin
         state <= IDLE;
         vic <= '0;
         data_out <= '0;
         hit_count <= '0;
         miss_count <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            dirty[s] <= '0;
            rr[s] <= '0;
         end
      end else
         case (state)
            IDLE:
               if (req && hit) begin
                  if (MemWrite) begin
                     lines[idx][hit_way][int'(off)*DATA_W +: DATA_W] <= data_in;
                     dirty[idx][hit_way] <= 1'b1;
                  end else data_out <= lines[idx][hit_way][int'(off)*DATA_W +: DATA_W];
                  hit_count <= hit_count + CNT_W'(!(&hit_count));
               end else if (req) begin
                  miss_count <= miss_count + CNT_W'(!(&miss_count));
                  vic <= victim;
                  state <= valid[idx][victim] && dirty[idx][victim] ? WRITEBACK : REFILL;
               end
            WRITEBACK: if (ack) state <= REFILL;
            REFILL:
               if (ack) begin
                  lines[idx][vic] <= rdata;
                  tags[idx][vic] <= tag;
                  valid[idx][vic] <= 1'b1;
                  dirty[idx][vic] <= 1'b0;
                  if (vic == rr[idx]) rr[idx] <= vic == WAY_W'(WAYS - 1) ? '0 : vic + WAY_W'(1);
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_data_mem_sys_assoc.sv
// tb_data_mem_sys_assoc: scoreboard bench, a flat-memory reference model predicts data, stall length and counters
module tb_data_mem_sys_assoc;
   localparam int L = 4;
   localparam int NW = 2;
   localparam int CW = 4;
   logic clk = 1'b0, reset = 1'b1, MemRead = 1'b0, MemWrite = 1'b0;
   logic [9:0] addr = '0;
   logic [31:0] data_in = '0, data_out;
   logic stall;
   logic [CW-1:0] hit_count, miss_count;
   always #5 clk = ~clk;
   data_mem_sys_assoc #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
      .data_in(data_in), .data_out(data_out), .stall(stall),
      .hit_count(hit_count), .miss_count(miss_count)
   );
   typedef struct {int stalls; logic [31:0] data; int hits; int misses;} exp_t;
   exp_t q[$];
   int tests = 0, fails = 0;
   logic [31:0] mm [1024];
   logic [31:0] arch [1024];
   bit m_valid [8][NW];
   bit m_dirty [8][NW];
   int m_tag [8][NW];
   int m_rr [8];
   int n_hit, n_miss;
   logic [31:0] m_dout;
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   function automatic void model_reset();
      for (int i = 0; i < 1024; i++) arch[i] = mm[i];
      for (int s = 0; s < 8; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < NW; w++) begin
            m_valid[s][w] = 0;
            m_dirty[s][w] = 0;
         end
      end
      n_hit = 0;
      n_miss = 0;
      m_dout = '0;
   endfunction
   function automatic exp_t predict(bit wr, int a, logic [31:0] d);
      exp_t e;
      int s = (a >> 2) & 7, t = a >> 5, w = -1;
      for (int i = 0; i < NW; i++) if (m_valid[s][i] && m_tag[s][i] == t) w = i;
      e.stalls = 0;
      if (w < 0) begin
         n_miss++;
         w = m_rr[s];
         for (int i = NW - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
         e.stalls = 1 + L;
         if (m_valid[s][w] && m_dirty[s][w]) begin
            e.stalls += L;
            for (int k = 0; k < 4; k++) mm[(m_tag[s][w] << 5) | (s << 2) | k] = arch[(m_tag[s][w] << 5) | (s << 2) | k];
         end
         m_valid[s][w] = 1;
         m_dirty[s][w] = 0;
         m_tag[s][w] = t;
         if (w == m_rr[s]) m_rr[s] = (w + 1) % NW;
      end
      n_hit++;
      if (wr) begin
         arch[a] = d;
         m_dirty[s][w] = 1;
      end else m_dout = arch[a];
      e.data = m_dout;
      e.hits = n_hit > 15 ? 15 : n_hit;
      e.misses = n_miss > 15 ? 15 : n_miss;
      return e;
   endfunction
   task automatic issue(bit rd, bit wr, logic [9:0] a, logic [31:0] d);
      int n = 0;
      q.push_back(predict(wr, int'(a), d));
      MemRead = rd;
      MemWrite = wr;
      addr = a;
      data_in = d;
      do begin
         @(negedge clk);
         n++;
      end while (stall && n < 40);
      if (stall) begin
         tests++;
         fails++;
         $display("FAIL timeout: stall still high after %0d cycles, addr %h", n, a);
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
      @(posedge clk);
      #2;
      MemRead = 1'b0;
      MemWrite = 1'b0;
   endtask
   task automatic post_reset_checks();
      chk("rst_stall", 32'(stall), 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_hit_count", 32'(hit_count), 0);
      chk("rst_miss_count", 32'(miss_count), 0);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      MemRead = 1'b0;
      MemWrite = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      model_reset();
      post_reset_checks();
   endtask
   initial begin
      int run = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) run = 0;
         else if (MemRead || MemWrite) begin
            if (stall) run++;
            else if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_completion: addr %h completed with no request outstanding", addr);
               run = 0;
            end else begin
               e = q.pop_front();
               chk("stall_cycles", run, e.stalls);
               run = 0;
               @(posedge clk);
               #1;
               chk("data_out", data_out, e.data);
               chk("hit_count", 32'(hit_count), e.hits);
               chk("miss_count", 32'(miss_count), e.misses);
            end
         end
      end
   end
   initial begin
      for (int i = 0; i < 1024; i++) mm[i] = i;
      do_reset();
      issue(1, 0, 10'h005, 0);
      issue(1, 0, 10'h006, 0);
      issue(0, 1, 10'h005, 32'hDEADBEEF);
      issue(1, 0, 10'h005, 0);
      issue(1, 0, 10'h025, 0);
      issue(1, 0, 10'h045, 0);
      issue(1, 0, 10'h005, 0);
      issue(1, 1, 10'h006, 32'h12345678);
      issue(1, 0, 10'h006, 0);
      MemRead = 1'b1;
      addr = 10'h0A5;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      MemRead = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b0;
      model_reset();
      post_reset_checks();
      issue(1, 0, 10'h0A5, 0);
      issue(1, 0, 10'h006, 0);
      issue(1, 0, 10'h005, 0);
      for (int i = 0; i < 300; i++) begin
         logic [9:0] a;
         int op;
         a = {5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         op = $urandom_range(0, 3);
         issue(op != 2, op >= 2, a, $urandom);
         if (i % 60 == 59) do_reset();
      end
      #20;
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
